// File: rtl/uart_autobaud.sv
// uart_autobaud: automatic baud-rate measurement for the AXIS UART.
// Once armed, it waits for the RX line to be idle-high, then times the first
// five falling edges of a 0x55 sync character. Those edges span 8 bit times,
// so the rounded total / 8 is the clocks-per-bit divider.
//
// Ports:
//   clk_i          system clock
//   arstn_i        asynchronous active-low reset
//   rx_i           raw UART RX line (asynchronous to clk_i)
//   start_i        single-cycle arm request (ignored while busy)
//   abort_i        return to IDLE without a pulse; result registers untouched
//   clk_divider_o  clocks-per-bit value driven to the UART core
//   locked_o       high while clk_divider_o holds a measured value
//   busy_o         high in every state except IDLE
//   done_o         one-cycle pulse on a successful measurement
//   err_o          one-cycle pulse on a failed measurement
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for start_i
// WAIT_HIGH  | counting consecutive synchronised-high RX cycles
// WAIT_START | line idle long enough; waiting for the start-bit edge
// MEASURE    | timing falling-edge to falling-edge intervals
// DONE       | done_o pulse cycle, result already loaded
// FAIL       | err_o pulse cycle, default divider already loaded
module uart_autobaud #(
  parameter int DIVIDER_WIDTH   = 32,
  parameter int DEFAULT_DIVIDER = 868,
  parameter int MIN_DIVIDER     = 4,
  parameter int IDLE_CYCLES     = 16,
  parameter int MAX_INTERVAL    = 2**20
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     rx_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  output logic [DIVIDER_WIDTH-1:0] clk_divider_o,
  output logic                     locked_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  // Interval counter must hold MAX_INTERVAL plus the 1.25 x I0 overrun window.
  localparam int IW = $clog2(MAX_INTERVAL) + 2;
  localparam int TW = DIVIDER_WIDTH + 3;
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_HIGH, WAIT_START, MEASURE, DONE, FAIL
  } state_t;

  state_t                   state;
  logic                     rx_s1, rx_s2, rx_d;
  logic                     fe;
  logic [IW-1:0]            interval;
  logic [IW-1:0]            i0;
  logic [2:0]               edge_cnt;
  logic [CW-1:0]            idle_cnt;
  logic [TW-1:0]            total;

  logic [IW-1:0]            dev, tol, limit;
  logic [TW-1:0]            total_next;
  logic [DIVIDER_WIDTH-1:0] result;
  logic                     meas_fail, meas_done;

  assign fe = rx_d & ~rx_s2;

  always_comb begin
    dev        = (interval >= i0) ? (interval - i0) : (i0 - interval);
    tol        = i0 >> 2;
    limit      = i0 + tol;
    total_next = total + TW'(interval);
    result     = DIVIDER_WIDTH'((total_next + TW'(4)) >> 3);
    meas_fail  = 1'b0;
    meas_done  = 1'b0;
    if (state == MEASURE) begin
      if (fe) begin
        // edge_cnt holds the number of edges seen before this one
        if (edge_cnt != 3'd1 && dev > tol) begin
          meas_fail = 1'b1;
        end else if (edge_cnt == 3'd4) begin
          if (result >= DIVIDER_WIDTH'(MIN_DIVIDER)) meas_done = 1'b1;
          else                                       meas_fail = 1'b1;
        end
      end else if (edge_cnt == 3'd1) begin
        meas_fail = (interval == IW'(MAX_INTERVAL));
      end else begin
        meas_fail = (interval > limit);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state         <= IDLE;
      rx_s1         <= 1'b1;
      rx_s2         <= 1'b1;
      rx_d          <= 1'b1;
      interval      <= '0;
      i0            <= '0;
      edge_cnt      <= '0;
      idle_cnt      <= '0;
      total         <= '0;
      clk_divider_o <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
      locked_o      <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      if (abort_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
        done_o <= 1'b0;
        err_o  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            if (start_i) begin
              state    <= WAIT_HIGH;
              busy_o   <= 1'b1;
              locked_o <= 1'b0;
              edge_cnt <= '0;
              idle_cnt <= '0;
            end
          end
          WAIT_HIGH: begin
            if (!rx_s2)                               idle_cnt <= '0;
            else if (idle_cnt == CW'(IDLE_CYCLES - 1)) state    <= WAIT_START;
            else                                      idle_cnt <= idle_cnt + 1'b1;
          end
          WAIT_START: begin
            if (fe) begin
              state    <= MEASURE;
              interval <= IW'(1);
              edge_cnt <= 3'd1;
              total    <= '0;
            end
          end
          MEASURE: begin
            if (meas_fail) begin
              state         <= FAIL;
              err_o         <= 1'b1;
              clk_divider_o <= DIVIDER_WIDTH'(DEFAULT_DIVIDER);
              locked_o      <= 1'b0;
            end else if (meas_done) begin
              state         <= DONE;
              done_o        <= 1'b1;
              clk_divider_o <= result;
              locked_o      <= 1'b1;
            end else if (fe) begin
              interval <= IW'(1);
              edge_cnt <= edge_cnt + 3'd1;
              if (edge_cnt == 3'd1) begin
                i0    <= interval;
                total <= TW'(interval);
              end else begin
                total <= total_next;
              end
            end else begin
              interval <= interval + 1'b1;
            end
          end
          DONE, FAIL: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
